// File: rtl/game_phase_sequencer.sv
// Round controller for the number game: IDLE -> FLASH -> MEMO -> PLAY -> WIN/LOSE.
// Drives the stage downcounters' restart pulses and tracks difficulty and score.
module game_phase_sequencer #(
  parameter int WIN_HOLD = 4,
  parameter int DIFF_MIN = 1
) (
  input  logic       halfsecclk,
  input  logic       resetn,
  input  logic       start,
  input  logic [3:0] diff_sel,
  input  logic       guess_valid,
  input  logic       guess_correct,
  input  logic [2:0] flash_cnt,
  input  logic [2:0] memo_cnt,
  input  logic [4:0] progress,
  output logic       secclk,
  output logic       flash_rstn,
  output logic       memo_rstn,
  output logic       play_rstn,
  output logic [3:0] difficulty,
  output logic [2:0] state,
  output logic [3:0] score
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLASH = 3'd1,
    S_MEMO  = 3'd2,
    S_PLAY  = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } phase_e;

  localparam int              HOLD_W     = (WIN_HOLD > 2) ? $clog2(WIN_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WIN_HOLD - 1);
  localparam logic [3:0]      DIFF_FLOOR = 4'(DIFF_MIN);

  phase_e            state_q, state_d;
  logic              secclk_q;
  logic              start_prev_q;
  logic              armed_q, armed_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        difficulty_q, difficulty_d;
  logic [3:0]        score_q, score_d;
  logic              flash_rstn_q, flash_rstn_d;
  logic              memo_rstn_q, memo_rstn_d;
  logic              play_rstn_q, play_rstn_d;

  logic start_rise;
  logic entering;

  assign start_rise = start & ~start_prev_q;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    difficulty_d = difficulty_q;
    score_d      = score_q;

    case (state_q)
      S_IDLE, S_LOSE: begin
        if (start_rise) begin
          state_d      = S_FLASH;
          difficulty_d = (diff_sel == 4'd0) ? 4'd1 : diff_sel;
          score_d      = 4'd0;
        end
      end
      S_FLASH: begin
        if (armed_q && flash_cnt == 3'd0) state_d = S_MEMO;
      end
      S_MEMO: begin
        if (armed_q && memo_cnt == 3'd0) state_d = S_PLAY;
      end
      S_PLAY: begin
        // A guess outranks the timer running out in the same cycle.
        if (armed_q) begin
          if (guess_valid) begin
            state_d = guess_correct ? S_WIN : S_LOSE;
          end else if (progress == 5'd0) begin
            state_d = S_LOSE;
          end
        end
        if (state_d == S_WIN) begin
          score_d      = (score_q == 4'hF) ? score_q : score_q + 4'd1;
          difficulty_d = (difficulty_q > DIFF_FLOOR) ? difficulty_q - 4'd1 : DIFF_FLOOR;
          hold_d       = '0;
        end
      end
      S_WIN: begin
        if (hold_q == HOLD_LAST) state_d = S_FLASH;
        else                     hold_d  = hold_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Counters restart during the first cycle of their stage; counter inputs
    // are trusted only from the second cycle, once the restart has landed.
    entering     = (state_d != state_q);
    armed_d      = ~entering;
    flash_rstn_d = ~(entering && state_d == S_FLASH);
    memo_rstn_d  = ~(entering && state_d == S_MEMO);
    play_rstn_d  = ~(entering && state_d == S_PLAY);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge halfsecclk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      secclk_q     <= 1'b0;
      start_prev_q <= 1'b0;
      armed_q      <= 1'b0;
      hold_q       <= '0;
      difficulty_q <= 4'd1;
      score_q      <= 4'd0;
      flash_rstn_q <= 1'b1;
      memo_rstn_q  <= 1'b1;
      play_rstn_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      secclk_q     <= ~secclk_q;
      start_prev_q <= start;
      armed_q      <= armed_d;
      hold_q       <= hold_d;
      difficulty_q <= difficulty_d;
      score_q      <= score_d;
      flash_rstn_q <= flash_rstn_d;
      memo_rstn_q  <= memo_rstn_d;
      play_rstn_q  <= play_rstn_d;
    end
  end

  assign secclk     = secclk_q;
  assign flash_rstn = flash_rstn_q;
  assign memo_rstn  = memo_rstn_q;
  assign play_rstn  = play_rstn_q;
  assign difficulty = difficulty_q;
  assign state      = state_q;
  assign score      = score_q;

endmodule

// File: tb/tb_game_phase_sequencer.sv
// Bench for game_phase_sequencer: directed round scenarios then random play,
// all compared cycle by cycle against a phase/age reference model.
module tb_game_phase_sequencer;

  localparam int WIN_HOLD = 4;
  localparam int DIFF_MIN = 1;
  localparam int IDLE = 0, FLASH = 1, MEMO = 2, PLAY = 3, WIN = 4, LOSE = 5;

  logic       halfsecclk = 1'b0;
  logic       resetn;
  logic       start = 1'b0;
  logic [3:0] diff_sel = 4'd0;
  logic       guess_valid = 1'b0;
  logic       guess_correct = 1'b0;
  logic [2:0] flash_cnt, memo_cnt;
  logic [4:0] progress = 5'd10;
  logic       secclk, flash_rstn, memo_rstn, play_rstn;
  logic [3:0] difficulty, score;
  logic [2:0] state;

  // Environment downcounters, restarted by the sequencer's active-low pulses.
  logic [2:0] flash_ctr = 3'd0;
  logic [2:0] memo_ctr  = 3'd0;
  logic       force_flash_zero = 1'b0;

  always #5 halfsecclk = ~halfsecclk;

  always @(posedge halfsecclk or negedge flash_rstn)
    if (!flash_rstn)          flash_ctr <= 3'd6;
    else if (flash_ctr != 0)  flash_ctr <= flash_ctr - 3'd1;

  always @(posedge halfsecclk or negedge memo_rstn)
    if (!memo_rstn)           memo_ctr <= 3'd5;
    else if (memo_ctr != 0)   memo_ctr <= memo_ctr - 3'd1;

  assign flash_cnt = force_flash_zero ? 3'd0 : flash_ctr;
  assign memo_cnt  = memo_ctr;

  game_phase_sequencer #(.WIN_HOLD(WIN_HOLD), .DIFF_MIN(DIFF_MIN)) dut (
    .halfsecclk   (halfsecclk),
    .resetn       (resetn),
    .start        (start),
    .diff_sel     (diff_sel),
    .guess_valid  (guess_valid),
    .guess_correct(guess_correct),
    .flash_cnt    (flash_cnt),
    .memo_cnt     (memo_cnt),
    .progress     (progress),
    .secclk       (secclk),
    .flash_rstn   (flash_rstn),
    .memo_rstn    (memo_rstn),
    .play_rstn    (play_rstn),
    .difficulty   (difficulty),
    .state        (state),
    .score        (score)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Reference model: phase plus cycles spent in it.
  int m_state, m_age, m_diff, m_score, m_secclk, m_prev;
  int n_state, n_age, n_diff, n_score, n_secclk, n_prev;

  task automatic model_reset();
    m_state = IDLE; m_age = 0; m_diff = 1; m_score = 0; m_secclk = 0; m_prev = 0;
  endtask

  task automatic model_next();
    bit rise, armed;
    rise  = start && (m_prev == 0);
    armed = (m_age >= 1);
    n_state = m_state; n_diff = m_diff; n_score = m_score;
    case (m_state)
      IDLE, LOSE:
        if (rise) begin
          n_state = FLASH;
          n_diff  = (diff_sel == 0) ? 1 : int'(diff_sel);
          n_score = 0;
        end
      FLASH: if (armed && flash_cnt == 0) n_state = MEMO;
      MEMO:  if (armed && memo_cnt == 0)  n_state = PLAY;
      PLAY: begin
        if (armed) begin
          if (guess_valid)        n_state = guess_correct ? WIN : LOSE;
          else if (progress == 0) n_state = LOSE;
        end
        if (n_state == WIN) begin
          n_score = (m_score < 15) ? m_score + 1 : 15;
          n_diff  = (m_diff - 1 < DIFF_MIN) ? DIFF_MIN : m_diff - 1;
        end
      end
      WIN: if (m_age == WIN_HOLD - 1) n_state = FLASH;
      default: n_state = IDLE;
    endcase
    n_age    = (n_state == m_state) ? m_age + 1 : 0;
    n_secclk = 1 - m_secclk;
    n_prev   = int'(start);
  endtask

  task automatic compare_all();
    check("state",      int'(state),      m_state);
    check("secclk",     int'(secclk),     m_secclk);
    check("difficulty", int'(difficulty), m_diff);
    check("score",      int'(score),      m_score);
    check("flash_rstn", int'(flash_rstn), (m_state == FLASH && m_age == 0) ? 0 : 1);
    check("memo_rstn",  int'(memo_rstn),  (m_state == MEMO  && m_age == 0) ? 0 : 1);
    check("play_rstn",  int'(play_rstn),  (m_state == PLAY  && m_age == 0) ? 0 : 1);
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    model_next();
    @(posedge halfsecclk);
    #1;
    m_state = n_state; m_age = n_age; m_diff = n_diff;
    m_score = n_score; m_secclk = n_secclk; m_prev = n_prev;
    compare_all();
    @(negedge halfsecclk);
  endtask

  task automatic run_until(input int target, input int budget, output int n);
    n = 0;
    while (m_state != target && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("reach_state_%0d", target), int'(state), target);
  endtask

  task automatic win_round();
    int n;
    progress = 5'd10; guess_valid = 1'b0;
    run_until(PLAY, 40, n);
    tick();
    guess_valid = 1'b1; guess_correct = 1'b1;
    tick();
    guess_valid = 1'b0;
    run_until(FLASH, 10, n);
  endtask

  initial begin
    int n;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    model_reset();
    #2;
    check("rst_state", int'(state), 0);
    check("rst_secclk", int'(secclk), 0);
    check("rst_diff", int'(difficulty), 1);
    check("rst_score", int'(score), 0);
    check("rst_rstn_all", int'({flash_rstn, memo_rstn, play_rstn}), 7);
    @(negedge halfsecclk);
    resetn = 1'b1;

    // First round: start with difficulty 3.
    start = 1'b1; diff_sel = 4'd3;
    tick();
    check("start_state", int'(state), FLASH);
    check("start_flash_rstn", int'(flash_rstn), 0);
    check("start_diff", int'(difficulty), 3);
    start = 1'b0;
    tick();
    check("flash_rstn_release", int'(flash_rstn), 1);
    run_until(MEMO, 20, n);
    check("flash_len", n + 1, 8);
    check("memo_rstn_pulse", int'(memo_rstn), 0);
    run_until(PLAY, 20, n);

    // Guess on the unarmed cycle is ignored, the next one wins.
    guess_valid = 1'b1; guess_correct = 1'b1;
    tick();
    check("unarmed_guess", int'(state), PLAY);
    tick();
    check("win_state", int'(state), WIN);
    check("win_score", int'(score), 1);
    check("win_diff", int'(difficulty), 2);
    guess_valid = 1'b0;
    run_until(FLASH, 10, n);
    check("win_hold_len", n, WIN_HOLD);

    for (int i = 0; i < 15; i++) win_round();
    check("score_sat", int'(score), 15);
    check("diff_floor", int'(difficulty), 1);

    // Correct guess in the same cycle as timeout wins.
    run_until(PLAY, 40, n);
    tick();
    progress = 5'd0; guess_valid = 1'b1; guess_correct = 1'b1;
    tick();
    check("guess_beats_timeout", int'(state), WIN);
    progress = 5'd10; guess_valid = 1'b0;
    run_until(FLASH, 10, n);

    // Timeout loses; start held through LOSE does not restart.
    run_until(PLAY, 40, n);
    tick();
    start = 1'b1; progress = 5'd0;
    tick();
    check("timeout_lose", int'(state), LOSE);
    progress = 5'd10;
    for (int i = 0; i < 3; i++) tick();
    check("held_start_ignored", int'(state), LOSE);
    start = 1'b0;
    tick();
    start = 1'b1; diff_sel = 4'd0;
    tick();
    check("restart_state", int'(state), FLASH);
    check("restart_diff0", int'(difficulty), 1);
    check("restart_score", int'(score), 0);
    start = 1'b0;

    // Wrong guess loses.
    run_until(PLAY, 40, n);
    tick();
    guess_valid = 1'b1; guess_correct = 1'b0;
    tick();
    check("wrong_guess_lose", int'(state), LOSE);
    guess_valid = 1'b0;

    // Stale zero on the flash counter is ignored on the unarmed cycle.
    force_flash_zero = 1'b1;
    start = 1'b1; diff_sel = 4'd5;
    tick();
    start = 1'b0;
    tick();
    check("stale_zero_ignored", int'(state), FLASH);
    tick();
    check("stale_zero_armed", int'(state), MEMO);
    force_flash_zero = 1'b0;

    // Asynchronous reset in MEMO after the restart pulse.
    tick();
    check("memo_rstn_high", int'(memo_rstn), 1);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check("async_state", int'(state), 0);
    check("async_score", int'(score), 0);
    check("async_diff", int'(difficulty), 1);
    check("async_secclk", int'(secclk), 0);
    check("async_rstn_all", int'({flash_rstn, memo_rstn, play_rstn}), 7);
    @(negedge halfsecclk);
    resetn = 1'b1;

    // Random play.
    for (int i = 0; i < 3000; i++) begin
      start         = ($urandom_range(0, 7) == 0);
      diff_sel      = 4'($urandom_range(0, 15));
      guess_valid   = ($urandom_range(0, 5) == 0);
      guess_correct = 1'($urandom_range(0, 1));
      progress      = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 10));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
